rv_fetch_queue: RTL and testbench

Parametrised instruction fetch stage for the uRV pipeline with a prefetch queue of configurable depth and support for multiple outstanding memory reads. Sits between the instruction memory port and the decode stage. Replaces the single-register fetch stage: it decouples memory latency from decode stalls and redirects cleanly on branches, discarding stale in-flight responses.

---
 rtl/rv_fetch_queue.sv | 160 ++++++++++++++++
 tb/tb_rv_fetch_queue.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_fetch_queue: prefetching instruction fetch stage with redirect flush  |
// | Optional: URV_FETCH_MISALIGN_EN adds f_misaligned_o and misaligned trap  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rv_fetch_queue #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  input  logic        f_stall_i,
  input  logic        f_kill_i,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
  output logic [31:0] f_pc_plus_4_o,
  output logic        f_valid_o,
  input  logic [31:0] x_pc_bra_i,
  input  logic        x_bra_i
`ifdef URV_FETCH_MISALIGN_EN
  ,
  output logic        f_misaligned_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  logic [31:0]      pc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] outs;
  logic [CNT_W-1:0] disc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] tag_rd;
  logic [PTR_W-1:0] tag_wr;
  logic [31:0]      q_ir   [DEPTH];
  logic [31:0]      q_pc   [DEPTH];
  logic [31:0]      tag_pc [DEPTH];

  logic [31:0]      target;
  logic             blocked;
  logic [OCC_W-1:0] occupancy;
  logic             issue;
  logic             push;
  logic             pop;

`ifdef URV_FETCH_MISALIGN_EN
  logic             halted;
  logic             bra_misaligned;
  logic             q_mis [DEPTH];

  assign target         = x_pc_bra_i;
  assign bra_misaligned = x_bra_i && (x_pc_bra_i[1:0] != 2'b00);
  assign blocked        = x_bra_i ? bra_misaligned : halted;
  assign f_misaligned_o = (count != '0) && q_mis[rd_ptr];
`else
  assign target  = x_pc_bra_i & 32'hFFFF_FFFC;
  assign blocked = 1'b0;
`endif

  // Occupancy counts both queued entries and every read still in flight,
  // so a response always has a free slot waiting for it.
  assign occupancy = {1'b0, count} + {1'b0, outs};
  assign issue     = rst_n_i && !blocked && (occupancy < DEPTH_C);
  assign im_rd_o   = issue;
  assign im_addr_o = x_bra_i ? target : pc;

  assign push = im_valid_i && (disc == '0) && !x_bra_i;
  assign pop  = (count != '0) && (!f_stall_i || f_kill_i);

  assign f_valid_o     = (count != '0) && !f_kill_i && !x_bra_i;
  assign f_ir_o        = q_ir[rd_ptr];
  assign f_pc_o        = q_pc[rd_ptr];
  assign f_pc_plus_4_o = q_pc[rd_ptr] + 32'd4;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc     <= RESET_VECTOR;
      count  <= '0;
      outs   <= '0;
      disc   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      tag_rd <= '0;
      tag_wr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_ir[i]   <= '0;
        q_pc[i]   <= '0;
        tag_pc[i] <= '0;
`ifdef URV_FETCH_MISALIGN_EN
        q_mis[i]  <= 1'b0;
`endif
      end
`ifdef URV_FETCH_MISALIGN_EN
      halted <= 1'b0;
`endif
    end else begin
      // The tag FIFO tracks every outstanding read, live or stale.
      if (issue) begin
        tag_pc[tag_wr] <= im_addr_o;
        tag_wr         <= tag_wr + PTR_W'(1);
      end
      if (im_valid_i) begin
        tag_rd <= tag_rd + PTR_W'(1);
      end
      outs <= outs + CNT_W'(issue) - CNT_W'(im_valid_i);

      if (x_bra_i) begin
        pc     <= issue ? target + 32'd4 : target;
        disc   <= outs - CNT_W'(im_valid_i);
        rd_ptr <= '0;
`ifdef URV_FETCH_MISALIGN_EN
        halted <= bra_misaligned;
        if (bra_misaligned) begin
          q_ir[0]  <= '0;
          q_pc[0]  <= x_pc_bra_i;
          q_mis[0] <= 1'b1;
          wr_ptr   <= PTR_W'(1);
          count    <= CNT_W'(1);
        end else begin
          wr_ptr <= '0;
          count  <= '0;
        end
`else
        wr_ptr <= '0;
        count  <= '0;
`endif
      end else begin
        if (issue) begin
          pc <= pc + 32'd4;
        end
        if (im_valid_i && (disc != '0)) begin
          disc <= disc - CNT_W'(1);
        end
        if (push) begin
          q_ir[wr_ptr]  <= im_data_i;
          q_pc[wr_ptr]  <= tag_pc[tag_rd];
`ifdef URV_FETCH_MISALIGN_EN
          q_mis[wr_ptr] <= 1'b0;
`endif
          wr_ptr        <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch_queue.sv
`default_nettype none
// Bench for rv_fetch_queue: directed scenarios plus randomized traffic
// checked against a transaction-level model of requests and queue entries.
module tb_rv_fetch_queue;

  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i = '0;
  logic        im_valid_i = 1'b0;
  logic        f_stall_i = 1'b0;
  logic        f_kill_i = 1'b0;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic [31:0] f_pc_plus_4_o;
  logic        f_valid_o;
  logic [31:0] x_pc_bra_i = '0;
  logic        x_bra_i = 1'b0;
  logic        f_misaligned_o;

  rv_fetch_queue #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .im_addr_o     (im_addr_o),
    .im_rd_o       (im_rd_o),
    .im_data_i     (im_data_i),
    .im_valid_i    (im_valid_i),
    .f_stall_i     (f_stall_i),
    .f_kill_i      (f_kill_i),
    .f_ir_o        (f_ir_o),
    .f_pc_o        (f_pc_o),
    .f_pc_plus_4_o (f_pc_plus_4_o),
    .f_valid_o     (f_valid_o),
    .x_pc_bra_i    (x_pc_bra_i),
    .x_bra_i       (x_bra_i)
`ifdef URV_FETCH_MISALIGN_EN
    ,
    .f_misaligned_o(f_misaligned_o)
`endif
  );

`ifndef URV_FETCH_MISALIGN_EN
  assign f_misaligned_o = 1'b0;
`endif

  always #5 clk = ~clk;

  // Model: in-flight reads carry a stale flag; the queue holds fetched entries.
  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] ir; logic [31:0] pc; bit mis; } ent_t;

  req_t        infl[$];
  ent_t        q[$];
  logic [31:0] m_pc = RV;
  bit          m_halt = 1'b0;
  int          t = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          passed = 0;
  int          total = 0;

  bit           resp;
  bit           e_rd;
  bit           mis_bra;
  logic [31:0]  eff_tgt;
  logic [130:0] exp_v;
  logic [130:0] obs_v;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic issue_req(input logic [31:0] a);
    int due;
    due = t + int'($urandom_range(lat_min, lat_max));
    if (due <= last_due) due = last_due + 1;
    last_due = due;
    infl.push_back('{a, due, 1'b0});
  endtask

  // Drive the memory response for this cycle, then sample and build expectations.
  task automatic step();
    bit          hv;
    bit          blocked;
    logic [31:0] e_addr;
    resp       = (infl.size() > 0) && (infl[0].due <= t);
    im_valid_i = resp;
    im_data_i  = resp ? memfn(infl[0].addr) : $urandom;
`ifdef URV_FETCH_MISALIGN_EN
    eff_tgt = x_pc_bra_i;
    mis_bra = x_bra_i && (x_pc_bra_i[1:0] != 2'b00);
`else
    eff_tgt = {x_pc_bra_i[31:2], 2'b00};
    mis_bra = 1'b0;
`endif
    blocked = x_bra_i ? mis_bra : m_halt;
    e_rd    = !blocked && ((q.size() + infl.size()) < DEPTH);
    e_addr  = x_bra_i ? eff_tgt : m_pc;
    hv      = q.size() > 0;
    #1;
    if (hv) begin
      exp_v = {e_rd, e_rd ? e_addr : 32'h0, !f_kill_i && !x_bra_i,
               q[0].pc, q[0].ir, q[0].pc + 32'd4, q[0].mis};
      obs_v = {im_rd_o, im_rd_o ? im_addr_o : 32'h0, f_valid_o,
               f_pc_o, f_ir_o, f_pc_plus_4_o, f_misaligned_o};
    end else begin
      exp_v = {e_rd, e_rd ? e_addr : 32'h0, 1'b0, 96'h0, 1'b0};
      obs_v = {im_rd_o, im_rd_o ? im_addr_o : 32'h0, f_valid_o, 96'h0, 1'b0};
    end
  endtask

  // Apply this cycle's events to the model and move to the next negedge.
  task automatic advance();
    req_t r;
    r = '{32'h0, 0, 1'b1};
    if (resp) r = infl.pop_front();
    if (x_bra_i) begin
      foreach (infl[i]) infl[i].stale = 1'b1;
      q.delete();
      m_halt = mis_bra;
      if (mis_bra) q.push_back('{32'h0, x_pc_bra_i, 1'b1});
      if (e_rd) begin
        issue_req(eff_tgt);
        m_pc = eff_tgt + 32'd4;
      end else begin
        m_pc = eff_tgt;
      end
    end else begin
      if (q.size() > 0 && (!f_stall_i || f_kill_i)) q.delete(0);
      if (resp && !r.stale) q.push_back('{memfn(r.addr), r.addr, 1'b0});
      if (e_rd) begin
        issue_req(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
    t++;
  endtask

  task automatic do_reset();
    f_stall_i  = 1'b0;
    f_kill_i   = 1'b0;
    x_bra_i    = 1'b0;
    im_valid_i = 1'b0;
    rst_n_i    = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();
    infl.delete();
    m_pc     = RV;
    m_halt   = 1'b0;
    last_due = 0;
    t        = 0;
    rst_n_i  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (f_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", f_valid_o); else passed++;
    total++; if (im_rd_o !== 1'b0) $display("FAIL reset_rd got=%b exp=0", im_rd_o); else passed++;
    total++; if (f_ir_o !== 32'h0) $display("FAIL reset_ir got=%h exp=0", f_ir_o); else passed++;
    total++; if (f_pc_o !== 32'h0) $display("FAIL reset_pc got=%h exp=0", f_pc_o); else passed++;
    total++; if (f_pc_plus_4_o !== 32'h4) $display("FAIL reset_pc4 got=%h exp=4", f_pc_plus_4_o); else passed++;
`ifdef URV_FETCH_MISALIGN_EN
    total++; if (f_misaligned_o !== 1'b0) $display("FAIL reset_mis got=%b exp=0", f_misaligned_o); else passed++;
`endif
  endtask

  task automatic test_reset_fetch();
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      total++; if (obs_v !== exp_v) $display("FAIL fetch t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      if (i == 0) begin
        total++; if (im_rd_o !== 1'b1 || im_addr_o !== RV) $display("FAIL first_req rd=%b addr=%h exp 1/%h", im_rd_o, im_addr_o, RV); else passed++;
      end
      if (i == 1) begin
        total++; if (f_valid_o !== 1'b0) $display("FAIL early_valid got=%b exp=0", f_valid_o); else passed++;
      end
      if (i == 2) begin
        total++; if (f_valid_o !== 1'b1 || f_pc_o !== RV || f_pc_plus_4_o !== RV + 32'd4)
          $display("FAIL first_valid v=%b pc=%h pc4=%h exp 1/%h/%h", f_valid_o, f_pc_o, f_pc_plus_4_o, RV, RV + 32'd4); else passed++;
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int n;
    int k;
    do_reset();
    lat_min = 1; lat_max = 1;
    f_stall_i = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (obs_v !== exp_v) $display("FAIL stall t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      if (im_rd_o === 1'b1) n++;
      advance();
    end
    total++; if (n != 4) $display("FAIL stall_reads got=%0d exp=4", n); else passed++;
    f_stall_i = 1'b0;
    k = 0;
    for (int i = 0; i < 16 && k < 4; i++) begin
      step();
      total++; if (obs_v !== exp_v) $display("FAIL release t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      if (f_valid_o === 1'b1) begin
        total++; if (f_pc_o !== RV + 32'(4 * k)) $display("FAIL drain_order got=%h exp=%h", f_pc_o, RV + 32'(4 * k)); else passed++;
        k++;
      end
      advance();
    end
    total++; if (k != 4) $display("FAIL drain_count got=%0d exp=4", k); else passed++;
  endtask

  task automatic test_redirect_inflight();
    bit done;
    int k;
    do_reset();
    lat_min = 3; lat_max = 3;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (infl.size() == 3) begin
        x_bra_i = 1'b1; x_pc_bra_i = 32'h2000; done = 1'b1;
      end
      step();
      total++; if (obs_v !== exp_v) $display("FAIL redir t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      advance();
      x_bra_i = 1'b0;
    end
    total++; if (!done) $display("FAIL redir_setup got=0 exp=1"); else passed++;
    k = 0;
    for (int i = 0; i < 15 && k < 2; i++) begin
      step();
      total++; if (obs_v !== exp_v) $display("FAIL redir_after t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      if (f_valid_o === 1'b1) begin
        total++; if (f_pc_o !== 32'h2000 + 32'(4 * k)) $display("FAIL redir_pc got=%h exp=%h", f_pc_o, 32'h2000 + 32'(4 * k)); else passed++;
        k++;
      end
      advance();
    end
    total++; if (k != 2) $display("FAIL redir_count got=%0d exp=2", k); else passed++;
  endtask

  task automatic test_kill();
    bit done;
    bit seen;
    do_reset();
    lat_min = 1; lat_max = 1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (q.size() > 0 && q[0].pc == 32'h108) begin
        f_kill_i = 1'b1; done = 1'b1;
      end
      step();
      total++; if (obs_v !== exp_v) $display("FAIL kill t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      if (f_kill_i) begin
        total++; if (f_valid_o !== 1'b0) $display("FAIL kill_valid got=%b exp=0", f_valid_o); else passed++;
      end
      advance();
      f_kill_i = 1'b0;
    end
    total++; if (!done) $display("FAIL kill_setup got=0 exp=1"); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      total++; if (obs_v !== exp_v) $display("FAIL kill_after t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      if (f_valid_o === 1'b1) begin
        total++; if (f_pc_o !== 32'h10C) $display("FAIL kill_next got=%h exp=0000010c", f_pc_o); else passed++;
        seen = 1'b1;
      end
      advance();
    end
    total++; if (!seen) $display("FAIL kill_timeout got=0 exp=1"); else passed++;
  endtask

  task automatic test_wrap();
    int k;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) begin
      x_bra_i = (i == 3);
      x_pc_bra_i = 32'hFFFF_FFFC;
      step();
      total++; if (obs_v !== exp_v) $display("FAIL wrap t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      advance();
    end
    x_bra_i = 1'b0;
    k = 0;
    for (int i = 0; i < 10 && k < 2; i++) begin
      step();
      total++; if (obs_v !== exp_v) $display("FAIL wrap_after t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      if (f_valid_o === 1'b1) begin
        if (k == 0) begin
          total++; if (f_pc_o !== 32'hFFFF_FFFC || f_pc_plus_4_o !== 32'h0)
            $display("FAIL wrap_first pc=%h pc4=%h exp fffffffc/00000000", f_pc_o, f_pc_plus_4_o); else passed++;
        end else begin
          total++; if (f_pc_o !== 32'h0) $display("FAIL wrap_second got=%h exp=00000000", f_pc_o); else passed++;
        end
        k++;
      end
      advance();
    end
    total++; if (k != 2) $display("FAIL wrap_count got=%0d exp=2", k); else passed++;
  endtask

`ifdef URV_FETCH_MISALIGN_EN
  task automatic test_misalign();
    int  n;
    bit  seen;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (obs_v !== exp_v) $display("FAIL mis_pre t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      advance();
    end
    x_bra_i = 1'b1; x_pc_bra_i = 32'h2002;
    step();
    total++; if (im_rd_o !== 1'b0) $display("FAIL mis_rd got=%b exp=0", im_rd_o); else passed++;
    advance();
    x_bra_i = 1'b0;
    step();
    total++; if (obs_v !== exp_v) $display("FAIL mis_entry t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
    total++; if (f_valid_o !== 1'b1 || f_pc_o !== 32'h2002 || f_misaligned_o !== 1'b1 || f_ir_o !== 32'h0)
      $display("FAIL mis_head v=%b pc=%h mis=%b ir=%h exp 1/00002002/1/00000000", f_valid_o, f_pc_o, f_misaligned_o, f_ir_o); else passed++;
    advance();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (obs_v !== exp_v) $display("FAIL mis_halt t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      if (im_rd_o === 1'b1) n++;
      advance();
    end
    total++; if (n != 0) $display("FAIL mis_halt_reads got=%0d exp=0", n); else passed++;
    x_bra_i = 1'b1; x_pc_bra_i = 32'h3000;
    step();
    total++; if (im_rd_o !== 1'b1 || im_addr_o !== 32'h3000) $display("FAIL mis_resume rd=%b addr=%h exp 1/00003000", im_rd_o, im_addr_o); else passed++;
    advance();
    x_bra_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      total++; if (obs_v !== exp_v) $display("FAIL mis_after t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      if (f_valid_o === 1'b1) begin
        total++; if (f_pc_o !== 32'h3000 || f_misaligned_o !== 1'b0) $display("FAIL mis_resume_head pc=%h mis=%b exp 00003000/0", f_pc_o, f_misaligned_o); else passed++;
        seen = 1'b1;
      end
      advance();
    end
    total++; if (!seen) $display("FAIL mis_resume_timeout got=0 exp=1"); else passed++;
  endtask
`endif

  task automatic test_random();
    int r;
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      f_stall_i = ($urandom_range(0, 9) < 3);
      f_kill_i  = ($urandom_range(0, 9) == 0);
      x_bra_i   = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 3));
      if (r == 0) x_pc_bra_i = 32'hFFFF_FFF8;
      else if (r == 1) x_pc_bra_i = $urandom;
      else x_pc_bra_i = $urandom & 32'hFFFF_FFFC;
      step();
      total++; if (obs_v !== exp_v) $display("FAIL random t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      advance();
    end
    f_stall_i = 1'b0; f_kill_i = 1'b0; x_bra_i = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (obs_v !== exp_v) $display("FAIL mid_pre t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      advance();
    end
    im_valid_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    total++; if (im_rd_o !== 1'b0 || f_valid_o !== 1'b0) $display("FAIL async_rst rd=%b v=%b exp 0/0", im_rd_o, f_valid_o); else passed++;
    total++; if (f_pc_o !== 32'h0 || f_ir_o !== 32'h0 || f_pc_plus_4_o !== 32'h4)
      $display("FAIL async_rst_head pc=%h ir=%h pc4=%h exp 0/0/4", f_pc_o, f_ir_o, f_pc_plus_4_o); else passed++;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (obs_v !== exp_v) $display("FAIL mid_post t=%0d got=%h exp=%h", t, obs_v, exp_v); else passed++;
      if (i == 0) begin
        total++; if (im_rd_o !== 1'b1 || im_addr_o !== RV) $display("FAIL mid_first rd=%b addr=%h exp 1/%h", im_rd_o, im_addr_o, RV); else passed++;
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_reset_fetch();
    test_backpressure();
    test_redirect_inflight();
    test_kill();
    test_wrap();
`ifdef URV_FETCH_MISALIGN_EN
    test_misalign();
`endif
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at t=%0d", t);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
